// File: rtl/even_par_rx.sv
// Even-parity serial frame receiver: start, DATA_W data bits (LSB first), parity, stop.
// Define EVEN_PAR_RX_ERR_CNT_EN to add the saturating 8-bit err_cnt output.
module even_par_rx #(
  parameter int unsigned DATA_W       = 4,
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rxd,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              par_err,
  output logic              frame_err,
`ifdef EVEN_PAR_RX_ERR_CNT_EN
  output logic [7:0]        err_cnt,
`endif
  output logic              busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(DATA_W - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StWaitHi} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_bit_q, par_bit_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              par_err_q, par_err_d;
  logic              frame_err_q, frame_err_d;
  logic              rx_valid_q, rx_valid_d;
  logic              sync_q, rxs;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 1'b1;
      rxs    <= 1'b1;
    end else begin
      sync_q <= rxd;
      rxs    <= sync_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      par_bit_q   <= 1'b0;
      rx_data_q   <= '0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rx_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      par_bit_q   <= par_bit_d;
      rx_data_q   <= rx_data_d;
      par_err_q   <= par_err_d;
      frame_err_q <= frame_err_d;
      rx_valid_q  <= rx_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    par_bit_d   = par_bit_q;
    rx_data_d   = rx_data_q;
    par_err_d   = par_err_q;
    frame_err_d = frame_err_q;
    rx_valid_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!rxs) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d = '0;
          idx_d = '0;
          // A start bit that is high again at mid-bit was only a glitch.
          state_d = rxs ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (cnt_q == BitLast) begin
          cnt_d          = '0;
          shift_d[idx_q] = rxs;
          if (idx_q == IdxLast) state_d = StParity;
          else                  idx_d   = idx_q + IdxW'(1);
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StParity: begin
        if (cnt_q == BitLast) begin
          cnt_d     = '0;
          par_bit_d = rxs;
          state_d   = StStop;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (cnt_q == BitLast) begin
          cnt_d       = '0;
          rx_data_d   = shift_q;
          par_err_d   = (^shift_q) ^ par_bit_q;
          frame_err_d = ~rxs;
          rx_valid_d  = 1'b1;
          // A low stop bit may be a break; wait for the line to recover.
          state_d     = rxs ? StIdle : StWaitHi;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWaitHi: begin
        if (rxs) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef EVEN_PAR_RX_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (rx_valid_d && (par_err_d || frame_err_d) && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign par_err   = par_err_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != StIdle);

endmodule
